load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage fed directly by the ALU: takes `alu_result` as the effective address plus rs2 store data and executes one RV32I load or store over a simple req/ready data-memory bus. Handles byte-lane steering, write strobes, load sign/zero extension, misalignment detection and a bus timeout. Stalls the single-cycle core through `busy` until the access completes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255, max ACCESS cycles waiting for `mem_ready` before bus error (1..65535)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request an access; sampled only in IDLE
- `is_store`  in  1  1 = store, 0 = load
- `funct3`  in  3  RV32I width/sign code
- `addr`  in  32  effective address (ALU `alu_result`)
- `store_data`  in  32  rs2 value
- `busy`  out  1  stall core (combinational)
- `done`  out  1  one-cycle completion pulse
- `load_data`  out  32  extended load result, valid with `done`
- `misaligned`  out  1  fault flag, valid with `done`
- `bus_err`  out  1  timeout flag, valid with `done`
- `mem_req`  out  1  bus request
- `mem_we`  out  1  bus write enable
- `mem_addr`  out  32  word address, `{addr[31:2],2'b00}`
- `mem_wdata`  out  32  lane-replicated store data
- `mem_wstrb`  out  4  byte strobes (0 on loads)
- `mem_rdata`  in  32  read data
- `mem_ready`  in  1  transfer complete this cycle

## Operation
- Clock `clk`; reset `rst_n` is asynchronous, active-low.
- FSM states: IDLE, ACCESS, DONE.
- IDLE + `start`: latch `is_store`, `funct3`, `addr`, `store_data`; run checks. Fault -> DONE with `misaligned`=1, no bus activity. Else -> ACCESS.
- Faults: LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`!=0; illegal funct3 (loads 011/110/111, stores 011..111) also reported as `misaligned`.
- ACCESS: `mem_req`=1, bus outputs stable. `mem_req & mem_ready` -> capture and extend read data (loads) -> DONE. Wait counter increments each ACCESS cycle without ready; reaching TIMEOUT_CYCLES -> drop `mem_req`, DONE with `bus_err`=1.
- DONE: `done`=1 for one cycle, -> IDLE. `start` in DONE is ignored.
- Store steering, lane = `addr[1:0]`: SB `mem_wdata`={4{sd[7:0]}}, `mem_wstrb`=4'b0001<<lane; SH {2{sd[15:0]}}, 4'b0011<<lane; SW full word, 4'b1111.
- Load extraction: LB/LBU byte `rdata[8*lane+:8]`; LH/LHU half `rdata[8*lane+:16]`; LW full. LB/LH sign-extend, LBU/LHU zero-extend.
- `load_data` = 0 on stores, faults and bus errors; held until next `done`.
- `busy` = (IDLE & `start`) | ACCESS; low in DONE so core advances that cycle.

## Timing
- Reset: all outputs 0, FSM IDLE, counter 0; immediate, including mid-ACCESS (`mem_req` drops asynchronously).
- Zero-wait access: `start` cycle 0, `mem_req` cycles 1, `mem_ready` cycle 1, `done` cycle 2. N wait states add N cycles.
- Fault: `start` cycle 0, `done`+`misaligned` cycle 1, `mem_req` never asserts.
- Timeout: `mem_req` high for exactly TIMEOUT_CYCLES cycles, `done`+`bus_err` next cycle.
- `mem_ready` on final timeout cycle: ready wins, normal completion, `bus_err`=0.
- `mem_ready` while `mem_req`=0: ignored.
- `start` outside IDLE: ignored; inputs changing during ACCESS do not affect bus outputs.
- Flags `misaligned`/`bus_err` mutually exclusive; registered, valid only in DONE, 0 otherwise.

## Test plan
- LB addr=0x1003, rdata=0x80FF_0000, zero wait -> `mem_addr`=0x1000, `done` cycle 2, `load_data`=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr=0x2002, store_data=0x1234_ABCD -> `mem_we`=1, `mem_wdata`=0xABCD_ABCD, `mem_wstrb`=4'b1100.
- LW addr=0x3001 -> `done`+`misaligned` cycle 1, `mem_req` never high; funct3=3'b111 load -> same.
- LW addr=0x4000, ready after 3 waits -> `mem_req` high 4 cycles, `busy` high cycles 0-4, `done` cycle 5.
- TIMEOUT_CYCLES=4, no ready -> `mem_req` 4 cycles, then `done`+`bus_err`, `load_data`=0; ready on 4th cycle -> normal completion.
- Deassert `rst_n` mid-ACCESS -> `mem_req`/`busy` drop immediately; after release, new LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store stage over a req/ready bus with lane steering, extension, fault and timeout detection
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic is_store_q, is_store_d, misaligned_q, misaligned_d, bus_err_q, bus_err_d, fault;
  logic [2:0] funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d, sd_q, sd_d, load_data_q, load_data_d, rsh, ext;
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    fault = (is_store ? (funct3[2] | (&funct3[1:0])) : ((&funct3[1:0]) | (funct3 == 3'b110)))
          | ((funct3[1:0] == 2'b01) & addr[0]) | ((funct3[1:0] == 2'b10) & (|addr[1:0]));
    rsh = mem_rdata >> {addr_q[1:0], 3'b000};
    ext = funct3_q[1] ? rsh
        : funct3_q[0] ? {{16{~funct3_q[2] & rsh[15]}}, rsh[15:0]}
        : {{24{~funct3_q[2] & rsh[7]}}, rsh[7:0]};
    state_d = state_q;
    is_store_d = is_store_q;
    funct3_d = funct3_q;
    addr_d = addr_q;
    sd_d = sd_q;
    load_data_d = load_data_q;
    misaligned_d = misaligned_q;
    bus_err_d = bus_err_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && start) begin
      is_store_d = is_store;
      funct3_d = funct3;
      addr_d = addr;
      sd_d = store_data;
      cnt_d = '0;
      misaligned_d = fault;
      load_data_d = fault ? '0 : load_data_q;
      state_d = fault ? DONE : ACCESS;
    end else if (state_q == ACCESS) begin
      if (mem_ready) begin
        state_d = DONE;
        load_data_d = is_store_q ? '0 : ext;
      end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
        state_d = DONE;
        bus_err_d = 1'b1;
        load_data_d = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
      misaligned_d = 1'b0;
      bus_err_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      is_store_q <= 1'b0;
      funct3_q <= '0;
      addr_q <= '0;
      sd_q <= '0;
      load_data_q <= '0;
      misaligned_q <= 1'b0;
      bus_err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      is_store_q <= is_store_d;
      funct3_q <= funct3_d;
      addr_q <= addr_d;
      sd_q <= sd_d;
      load_data_q <= load_data_d;
      misaligned_q <= misaligned_d;
      bus_err_q <= bus_err_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy = ((state_q == IDLE) & start) | (state_q == ACCESS);
  assign done = state_q == DONE;
  assign load_data = load_data_q;
  assign misaligned = misaligned_q;
  assign bus_err = bus_err_q;
  assign mem_req = state_q == ACCESS;
  assign mem_we = mem_req & is_store_q;
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign mem_wdata = funct3_q[1] ? sd_q : funct3_q[0] ? {2{sd_q[15:0]}} : {4{sd_q[7:0]}};
  assign mem_wstrb = mem_we ? (funct3_q[1] ? 4'hf : (funct3_q[0] ? 4'b0011 : 4'b0001) << addr_q[1:0]) : 4'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a behavioural access model
module tb_load_store_unit;
  localparam int TO = 4;
  typedef struct {
    logic st;
    logic [2:0] f3;
    logic [31:0] a, sd, rd;
    int waits;
  } op_t;
  logic clk = 0, rst_n = 0, start = 0, is_store = 0, mem_ready = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, store_data = 0, mem_rdata = 0;
  logic busy, done, misaligned, bus_err, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  int pass_cnt = 0, total_cnt = 0;
  op_t plan[8] = '{
    '{1'b0, 3'd0, 32'h1003, 32'h0, 32'h80FF_0000, 0},
    '{1'b0, 3'd4, 32'h1003, 32'h0, 32'h80FF_0000, 0},
    '{1'b1, 3'd1, 32'h2002, 32'h1234_ABCD, 32'h0, 0},
    '{1'b0, 3'd2, 32'h3001, 32'h0, 32'h0, 0},
    '{1'b0, 3'd7, 32'h3000, 32'h0, 32'h0, 0},
    '{1'b0, 3'd2, 32'h4000, 32'h0, 32'hDEAD_BEEF, 3},
    '{1'b0, 3'd2, 32'h5000, 32'h0, 32'hDEAD_BEEF, 99},
    '{1'b1, 3'd2, 32'h6000, 32'hCAFE_F00D, 32'h0, 3}
  };
  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done), .load_data(load_data),
    .misaligned(misaligned), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  always #5 clk = ~clk;
  task automatic model(input op_t o, output int dcyc, rcyc, output logic mis, err,
                       output logic [31:0] ld, wdata, output logic [3:0] wstrb);
    int size, lane;
    bit sgn, ill;
    longint v;
    size = 1; sgn = 0; ill = 0;
    case (o.f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: ill = 1;
    endcase
    if (o.st && o.f3 > 3'd2) ill = 1;
    lane = int'(o.a & 32'h3);
    mis = ill || (lane % size != 0);
    err = 0;
    wstrb = 0;
    wdata = 0;
    for (int i = 0; i < 4; i++) begin
      wdata[8*i+:8] = o.sd[8*(i%size)+:8];
      wstrb[i] = o.st && i >= lane && i < lane + size;
    end
    v = 0;
    for (int k = 0; k < size; k++) v = v | (longint'((o.rd >> (8*(lane+k))) & 32'hff) << (8*k));
    if (sgn && v >= (longint'(1) << (8*size-1))) v = v - (longint'(1) << (8*size));
    ld = o.st ? 32'h0 : v[31:0];
    if (mis) begin
      dcyc = 1; rcyc = 0; ld = 0; wstrb = 0;
    end else if (o.waits < TO) begin
      rcyc = o.waits + 1; dcyc = o.waits + 2;
    end else begin
      rcyc = TO; dcyc = TO + 1; err = 1; ld = 0;
    end
  endtask
  task automatic run_op(input op_t o, output int dcyc, rcyc, bad, output logic mis, err, gwe,
                        output logic [31:0] ld, gaddr, gwdata, output logic [3:0] gstrb);
    dcyc = -1; rcyc = 0; bad = 0; mis = 0; err = 0; ld = 0;
    gwe = 0; gaddr = 0; gwdata = 0; gstrb = 0;
    start = 1; is_store = o.st; funct3 = o.f3; addr = o.a; store_data = o.sd;
    mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    #1 if (busy !== 1'b1 || mem_req !== 1'b0) bad++;
    for (int c = 1; c <= TO + 10; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        dcyc = c; ld = load_data; mis = misaligned; err = bus_err;
        if (busy !== 1'b0 || mem_req !== 1'b0) bad++;
        start = 0; mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (done !== 1'b0 || misaligned !== 1'b0 || bus_err !== 1'b0 || load_data !== ld || busy !== 1'b0) bad++;
        mem_ready = 0;
        break;
      end
      if (busy !== 1'b1 || mem_req !== 1'b1 || misaligned !== 1'b0 || bus_err !== 1'b0) bad++;
      rcyc++;
      if (rcyc == 1) begin
        gwe = mem_we; gaddr = mem_addr; gwdata = mem_wdata; gstrb = mem_wstrb;
      end else if ({gwe, gaddr, gwdata, gstrb} !== {mem_we, mem_addr, mem_wdata, mem_wstrb}) bad++;
      mem_ready = (rcyc == o.waits + 1);
      mem_rdata = mem_ready ? o.rd : $urandom;
      start = 1'($urandom_range(0, 1)); is_store = 1'($urandom); funct3 = 3'($urandom);
      addr = $urandom; store_data = $urandom;
    end
    start = 0;
  endtask
  task automatic test_reset;
    total_cnt++;
    if ({busy, done, misaligned, bus_err, mem_req, mem_we, mem_wstrb} !== 10'h0)
      $display("FAIL reset_flags got=%b exp=0", {busy, done, misaligned, bus_err, mem_req, mem_we, mem_wstrb});
    else pass_cnt++;
    total_cnt++;
    if ({load_data, mem_addr, mem_wdata} !== 96'h0)
      $display("FAIL reset_data got=%h/%h/%h exp=0", load_data, mem_addr, mem_wdata);
    else pass_cnt++;
  endtask
  task automatic test_access(input string tag, input int n, input bit rnd);
    op_t o;
    int ed, er, gd, gr, bad;
    logic emis, eerr, gmis, gerr, gwe;
    logic [31:0] eld, ewd, gld, gaddr, gwd;
    logic [3:0] ews, gws;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        o.st = 1'($urandom);
        o.f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : (o.st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
        o.a = $urandom & (($urandom_range(0, 2) == 0) ? 32'hffff_ffff : 32'hffff_fffc);
        o.sd = $urandom; o.rd = $urandom; o.waits = $urandom_range(0, TO + 1);
      end else o = plan[i];
      model(o, ed, er, emis, eerr, eld, ewd, ews);
      run_op(o, gd, gr, bad, gmis, gerr, gwe, gld, gaddr, gwd, gws);
      total_cnt++;
      if (gd !== ed) $display("FAIL %s[%0d] done_cycle got=%0d exp=%0d", tag, i, gd, ed); else pass_cnt++;
      total_cnt++;
      if (gr !== er) $display("FAIL %s[%0d] req_cycles got=%0d exp=%0d", tag, i, gr, er); else pass_cnt++;
      total_cnt++;
      if ({gmis, gerr} !== {emis, eerr}) $display("FAIL %s[%0d] mis_err got=%b%b exp=%b%b", tag, i, gmis, gerr, emis, eerr); else pass_cnt++;
      total_cnt++;
      if (gld !== eld) $display("FAIL %s[%0d] load_data got=%h exp=%h", tag, i, gld, eld); else pass_cnt++;
      total_cnt++;
      if (bad !== 0) $display("FAIL %s[%0d] protocol_violations got=%0d exp=0", tag, i, bad); else pass_cnt++;
      if (er > 0) begin
        total_cnt++;
        if ({gwe, gaddr, gws} !== {o.st, o.a & 32'hffff_fffc, ews})
          $display("FAIL %s[%0d] bus we/addr/strb got=%b/%h/%b exp=%b/%h/%b", tag, i, gwe, gaddr, gws, o.st, o.a & 32'hffff_fffc, ews);
        else pass_cnt++;
        if (o.st) begin
          total_cnt++;
          if (gwd !== ewd) $display("FAIL %s[%0d] wdata got=%h exp=%h", tag, i, gwd, ewd); else pass_cnt++;
        end
      end
    end
  endtask
  task automatic test_reset_mid_access;
    op_t o;
    int gd, gr, bad;
    logic gmis, gerr, gwe;
    logic [31:0] gld, gaddr, gwd;
    logic [3:0] gws;
    start = 1; is_store = 0; funct3 = 3'd2; addr = 32'h7000; mem_ready = 0;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1;
    total_cnt++;
    if (mem_req !== 1'b1) $display("FAIL mid_reset pre mem_req got=%b exp=1", mem_req); else pass_cnt++;
    #2 rst_n = 0;
    #1;
    total_cnt++;
    if ({mem_req, busy, done} !== 3'b000) $display("FAIL mid_reset req/busy/done got=%b exp=000", {mem_req, busy, done}); else pass_cnt++;
    #2 rst_n = 1;
    @(posedge clk); #1;
    o = '{1'b0, 3'd2, 32'h7004, 32'h0, 32'h0BAD_F00D, 1};
    run_op(o, gd, gr, bad, gmis, gerr, gwe, gld, gaddr, gwd, gws);
    total_cnt++;
    if ({gd, gr} !== {32'd3, 32'd2}) $display("FAIL post_reset cycles got=%0d/%0d exp=3/2", gd, gr); else pass_cnt++;
    total_cnt++;
    if ({gld, gmis, gerr, bad} !== {32'h0BAD_F00D, 2'b00, 32'd0}) $display("FAIL post_reset load got=%h %b%b %0d exp=0badf00d 00 0", gld, gmis, gerr, bad); else pass_cnt++;
  endtask
  initial begin
    #200000 $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1;
    @(posedge clk); #1;
    test_access("plan", 8, 0);
    test_access("rand", 60, 1);
    test_reset_mid_access;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
